// File: rtl/setn_sequencer.sv
// Sequences active-low SETN strobes across the enabled banks, one bank at a time.
// Optional SETN_SEQ_CNT_EN adds an 8-bit wrapping count of completed sequences on SEQ_CNT.
module setn_sequencer #(
    parameter int NBANK     = 4,
    parameter int PULSE_CYC = 3,
    parameter int GAP_CYC   = 1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             REQ,
    input  logic [NBANK-1:0] BANK_MASK,
    output logic [NBANK-1:0] SETN,
    output logic             BUSY,
    output logic             DONE
`ifdef SETN_SEQ_CNT_EN
    ,
    output logic [7:0]       SEQ_CNT
`endif
);
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q;
    logic             run;
    logic [NBANK-1:0] mask_q, mask_d;
    logic [NBANK-1:0] setn_q, setn_d;
    logic [BW-1:0]    bank_q, bank_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             first_vld, next_vld;
    logic [BW-1:0]    first_idx, next_idx;

    function automatic logic [NBANK-1:0] strobe(input logic [BW-1:0] idx);
        logic [NBANK-1:0] s;
        s      = '1;
        s[idx] = 1'b0;
        return s;
    endfunction

    // Reset release passes through two flops; the FSM only acts once sync_q[1] is set.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign run = sync_q[1];

    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        next_vld  = 1'b0;
        next_idx  = '0;
        // Scanning downwards leaves the lowest qualifying index as the winner.
        for (int i = NBANK - 1; i >= 0; i--) begin
            if (BANK_MASK[i]) begin
                first_vld = 1'b1;
                first_idx = BW'(i);
            end
            if (mask_q[i] && (i > int'(bank_q))) begin
                next_vld = 1'b1;
                next_idx = BW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        setn_d  = setn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run && REQ) begin
                    mask_d = BANK_MASK;
                    busy_d = 1'b1;
                    if (first_vld) begin
                        state_d = S_PULSE;
                        bank_d  = first_idx;
                        cnt_d   = PULSE_LAST;
                        setn_d  = strobe(first_idx);
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_PULSE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    setn_d = '1;
                    cnt_d  = 8'd0;
                    if (!next_vld) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else if (GAP_CYC == 0) begin
                        bank_d = next_idx;
                        cnt_d  = PULSE_LAST;
                        setn_d = strobe(next_idx);
                    end else begin
                        state_d = S_GAP;
                        bank_d  = next_idx;
                        cnt_d   = GAP_LAST;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = S_PULSE;
                    cnt_d   = PULSE_LAST;
                    setn_d  = strobe(bank_q);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            bank_q  <= '0;
            cnt_q   <= 8'd0;
            setn_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
            setn_q  <= setn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SETN = setn_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

`ifdef SETN_SEQ_CNT_EN
    logic [7:0] seq_cnt_q;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            seq_cnt_q <= 8'd0;
        end else if (state_q == S_FIN) begin
            seq_cnt_q <= seq_cnt_q + 8'd1;
        end
    end

    assign SEQ_CNT = seq_cnt_q;
`endif

endmodule

// File: tb/tb_setn_sequencer.sv
// Scoreboard bench for setn_sequencer: dut_a uses the default timing, dut_b has no gap.
`timescale 1ns/1ps
module tb_setn_sequencer;
    logic       clk = 1'b0;
    logic       rn  = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [3:0] mask_a = 4'h0, mask_b = 4'h0;
    logic [3:0] setn_a, setn_b;
    logic       busy_a, busy_b, done_a, done_b;
`ifdef SETN_SEQ_CNT_EN
    logic [7:0] cnt_a, cnt_b;
    logic [7:0] exp_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] setn;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    setn_sequencer #(.NBANK(4), .PULSE_CYC(3), .GAP_CYC(1)) dut_a (
        .CLK(clk), .RN(rn), .REQ(req_a), .BANK_MASK(mask_a),
        .SETN(setn_a), .BUSY(busy_a), .DONE(done_a)
`ifdef SETN_SEQ_CNT_EN
        , .SEQ_CNT(cnt_a)
`endif
    );

    setn_sequencer #(.NBANK(4), .PULSE_CYC(3), .GAP_CYC(0)) dut_b (
        .CLK(clk), .RN(rn), .REQ(req_b), .BANK_MASK(mask_b),
        .SETN(setn_b), .BUSY(busy_b), .DONE(done_b)
`ifdef SETN_SEQ_CNT_EN
        , .SEQ_CNT(cnt_b)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [5:0] obs(input int sel);
        return (sel == 0) ? {setn_a, busy_a, done_a} : {setn_b, busy_b, done_b};
    endfunction

    task automatic set_req(input int sel, input logic r, input logic [3:0] m);
        if (sel == 0) begin
            req_a  = r;
            mask_a = m;
        end else begin
            req_b  = r;
            mask_b = m;
        end
    endtask

    // Expected per-cycle outputs from the cycle after acceptance through FIN.
    task automatic push_expect(input int sel, input logic [3:0] mask);
        exp_t e;
        int   gap;
        bit   first;
        gap   = (sel == 0) ? 1 : 0;
        first = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                if (!first) begin
                    for (int g = 0; g < gap; g++) begin
                        e.setn = 4'hF; e.busy = 1'b1; e.done = 1'b0;
                        sb.push_back(e);
                    end
                end
                for (int p = 0; p < 3; p++) begin
                    e.setn = 4'hF; e.setn[i] = 1'b0; e.busy = 1'b1; e.done = 1'b0;
                    sb.push_back(e);
                end
                first = 1'b0;
            end
        end
        e.setn = 4'hF; e.busy = 1'b1; e.done = 1'b1;
        sb.push_back(e);
    endtask

    // mode 0: REQ pulse; mode 1: REQ and mask disturbed while busy; mode 2: REQ left high.
    task automatic run_seq(input int sel, input logic [3:0] mask, input int mode);
        exp_t e;
        int   cyc;
        push_expect(sel, mask);
        set_req(sel, 1'b1, mask);
        cyc = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            if (mode == 1) set_req(sel, (sb.size() > 0), 4'hF);
            else if (mode == 0) set_req(sel, 1'b0, mask);
            check_val($sformatf("dut%0d m%h c%0d", sel, mask, cyc), 32'(obs(sel)), 32'(e));
            cyc++;
        end
        @(negedge clk);
        check_val($sformatf("dut%0d m%h idle", sel, mask), 32'(obs(sel)), 32'(6'b111100));
        if (mode != 2) set_req(sel, 1'b0, mask);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_val("reset_a", 32'(obs(0)), 32'(6'b111100));
        check_val("reset_b", 32'(obs(1)), 32'(6'b111100));
        rn = 1'b1;
        repeat (2) @(negedge clk);

        run_seq(0, 4'b1011, 0);
        run_seq(0, 4'b0000, 0);
        run_seq(1, 4'b0011, 0);
        run_seq(1, 4'b1001, 0);
        run_seq(0, 4'b1000, 0);
        run_seq(0, 4'b0110, 1);
        @(negedge clk);
        check_val("no_requeue", 32'(obs(0)), 32'(6'b111100));
        run_seq(0, 4'b0101, 2);
        run_seq(0, 4'b0101, 0);

        // Asynchronous reset in the second cycle of the SETN[1] pulse.
        set_req(0, 1'b1, 4'b1011);
        @(negedge clk);
        set_req(0, 1'b0, 4'b1011);
        repeat (5) @(negedge clk);
        check_val("pre_rst", 32'(obs(0)), 32'(6'b110110));
        #2 rn = 1'b0;
        #1 check_val("async_rst", 32'(obs(0)), 32'(6'b111100));
        @(negedge clk);
        check_val("held_rst", 32'(obs(0)), 32'(6'b111100));
        rn = 1'b1;
        set_req(0, 1'b1, 4'b1011);
        @(negedge clk);
        check_val("sync_edge1", 32'(obs(0)), 32'(6'b111100));
        @(negedge clk);
        check_val("sync_edge2", 32'(obs(0)), 32'(6'b111100));
        run_seq(0, 4'b1011, 0);

`ifdef SETN_SEQ_CNT_EN
        rn = 1'b0;
        @(negedge clk);
        check_val("seq_cnt_rst", 32'(cnt_a), 32'(0));
        rn = 1'b1;
        repeat (2) @(negedge clk);
        exp_cnt = 8'd0;
        for (int k = 1; k <= 256; k++) begin
            run_seq(0, 4'b0000, 0);
            exp_cnt = exp_cnt + 8'd1;
            if (k >= 255) check_val($sformatf("seq_cnt_%0d", k), 32'(cnt_a), 32'(exp_cnt));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
